fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 189 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: drives the imem request and fills the IF/ID pipeline register.
// Bubble encoding is selected by IFID_BUBBLE_NOP_EN (addi x0,x0,0 when defined, all-zero otherwise).
module fetch_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush_IF,
  input  logic [31:0] PC_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrCode_ID,
  output logic [31:0] PC_ID,
  output logic [31:0] PC4_ID,
  output logic        valid_ID
);

`ifdef IFID_BUBBLE_NOP_EN
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0013;
`else
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
`endif

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_fetch_addr;
  logic [31:0] r_pend_addr;
  logic [31:0] r_hold_instr;
  logic [31:0] r_hold_pc;
  logic [31:0] r_instr_id;
  logic [31:0] r_pc_id;
  logic [31:0] r_pc4_id;
  logic        r_valid_id;

  logic [31:0] w_fetch_addr_nxt;
  logic [31:0] w_pend_addr_nxt;
  logic [31:0] w_hold_instr_nxt;
  logic [31:0] w_hold_pc_nxt;
  logic [31:0] w_instr_id_nxt;
  logic [31:0] w_pc_id_nxt;
  logic [31:0] w_pc4_id_nxt;
  logic        w_valid_id_nxt;
  logic [31:0] w_fetch_addr_inc;
  logic [31:0] w_hold_pc_inc;

  // Address arithmetic wraps naturally at 32 bits.
  assign w_fetch_addr_inc = r_fetch_addr + 32'd4;
  assign w_hold_pc_inc    = r_hold_pc + 32'd4;

  always_comb begin
    w_state_nxt      = r_state;
    w_fetch_addr_nxt = r_fetch_addr;
    w_pend_addr_nxt  = r_pend_addr;
    w_hold_instr_nxt = r_hold_instr;
    w_hold_pc_nxt    = r_hold_pc;
    w_instr_id_nxt   = r_instr_id;
    w_pc_id_nxt      = r_pc_id;
    w_pc4_id_nxt     = r_pc4_id;
    w_valid_id_nxt   = r_valid_id;
    imem_req         = 1'b0;
    imem_addr        = r_fetch_addr;

    case (r_state)
      FETCH: begin
        imem_req = 1'b1;
        if (flush_IF) begin
          w_instr_id_nxt = BUBBLE_INSTR;
          w_pc_id_nxt    = 32'd0;
          w_pc4_id_nxt   = 32'd0;
          w_valid_id_nxt = 1'b0;
          if (imem_ready) begin
            w_fetch_addr_nxt = PC_target;
          end else begin
            // Request stays on the bus until memory answers; its data is dropped.
            w_pend_addr_nxt = PC_target;
            w_state_nxt     = DRAIN;
          end
        end else if (imem_ready) begin
          if (stall) begin
            w_hold_instr_nxt = imem_rdata;
            w_hold_pc_nxt    = r_fetch_addr;
            w_state_nxt      = HOLD;
          end else begin
            w_instr_id_nxt   = imem_rdata;
            w_pc_id_nxt      = r_fetch_addr;
            w_pc4_id_nxt     = w_fetch_addr_inc;
            w_valid_id_nxt   = 1'b1;
            w_fetch_addr_nxt = w_fetch_addr_inc;
          end
        end else if (!stall) begin
          w_instr_id_nxt = BUBBLE_INSTR;
          w_pc_id_nxt    = 32'd0;
          w_pc4_id_nxt   = 32'd0;
          w_valid_id_nxt = 1'b0;
        end
      end

      HOLD: begin
        if (flush_IF) begin
          w_instr_id_nxt   = BUBBLE_INSTR;
          w_pc_id_nxt      = 32'd0;
          w_pc4_id_nxt     = 32'd0;
          w_valid_id_nxt   = 1'b0;
          w_hold_instr_nxt = 32'd0;
          w_hold_pc_nxt    = 32'd0;
          w_fetch_addr_nxt = PC_target;
          w_state_nxt      = FETCH;
        end else if (!stall) begin
          w_instr_id_nxt   = r_hold_instr;
          w_pc_id_nxt      = r_hold_pc;
          w_pc4_id_nxt     = w_hold_pc_inc;
          w_valid_id_nxt   = 1'b1;
          w_hold_instr_nxt = 32'd0;
          w_hold_pc_nxt    = 32'd0;
          w_fetch_addr_nxt = w_fetch_addr_inc;
          w_state_nxt      = FETCH;
        end
      end

      DRAIN: begin
        imem_req = 1'b1;
        if (flush_IF) begin
          w_instr_id_nxt  = BUBBLE_INSTR;
          w_pc_id_nxt     = 32'd0;
          w_pc4_id_nxt    = 32'd0;
          w_valid_id_nxt  = 1'b0;
          w_pend_addr_nxt = PC_target;
          if (imem_ready) begin
            w_fetch_addr_nxt = PC_target;
            w_state_nxt      = FETCH;
          end
        end else begin
          if (!stall) begin
            w_instr_id_nxt = BUBBLE_INSTR;
            w_pc_id_nxt    = 32'd0;
            w_pc4_id_nxt   = 32'd0;
            w_valid_id_nxt = 1'b0;
          end
          if (imem_ready) begin
            w_fetch_addr_nxt = r_pend_addr;
            w_state_nxt      = FETCH;
          end
        end
      end

      default: begin
        w_state_nxt = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= FETCH;
      r_fetch_addr <= 32'd0;
      r_pend_addr  <= 32'd0;
      r_hold_instr <= 32'd0;
      r_hold_pc    <= 32'd0;
      r_instr_id   <= BUBBLE_INSTR;
      r_pc_id      <= 32'd0;
      r_pc4_id     <= 32'd0;
      r_valid_id   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fetch_addr <= w_fetch_addr_nxt;
      r_pend_addr  <= w_pend_addr_nxt;
      r_hold_instr <= w_hold_instr_nxt;
      r_hold_pc    <= w_hold_pc_nxt;
      r_instr_id   <= w_instr_id_nxt;
      r_pc_id      <= w_pc_id_nxt;
      r_pc4_id     <= w_pc4_id_nxt;
      r_valid_id   <= w_valid_id_nxt;
    end
  end

  assign instrCode_ID = r_instr_id;
  assign PC_ID        = r_pc_id;
  assign PC4_ID       = r_pc4_id;
  assign valid_ID     = r_valid_id;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;

`ifdef IFID_BUBBLE_NOP_EN
  localparam logic [31:0] BUB = 32'h0000_0013;
`else
  localparam logic [31:0] BUB = 32'h0000_0000;
`endif

  logic        clk = 1'b0;
  logic        reset, stall, flush_IF, imem_ready;
  logic [31:0] PC_target, imem_rdata;
  logic        imem_req, valid_ID;
  logic [31:0] imem_addr, instrCode_ID, PC_ID, PC4_ID;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush_IF(flush_IF), .PC_target(PC_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instrCode_ID(instrCode_ID), .PC_ID(PC_ID), .PC4_ID(PC4_ID), .valid_ID(valid_ID)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] salt = 32'd0;

  // Model: next fetch address, optional held instruction, optional doomed in-flight request.
  bit          m_held;
  logic [31:0] m_held_ins;
  bit          m_doomed;
  logic [31:0] m_redir;
  logic [31:0] m_pc;
  bit          m_v;
  logic [31:0] m_ins, m_pcid, m_pc4;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
  endtask

  task automatic set_bubble();
    m_v = 1'b0; m_ins = BUB; m_pcid = 32'd0; m_pc4 = 32'd0;
  endtask

  task automatic deliver(input logic [31:0] ins);
    m_v = 1'b1; m_ins = ins; m_pcid = m_pc; m_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
  endtask

  task automatic model_step(input bit rst, input bit st, input bit fl, input logic [31:0] tg,
                            input bit rdy, input logic [31:0] rd);
    if (rst) begin
      m_held = 1'b0; m_held_ins = 32'd0; m_doomed = 1'b0; m_redir = 32'd0; m_pc = 32'd0;
      set_bubble();
    end else if (m_held) begin
      if (fl) begin
        set_bubble(); m_held = 1'b0; m_pc = tg;
      end else if (!st) begin
        deliver(m_held_ins); m_held = 1'b0;
      end
    end else begin
      if (fl) begin
        set_bubble();
        if (rdy) begin m_pc = tg; m_doomed = 1'b0; end
        else begin m_doomed = 1'b1; m_redir = tg; end
      end else if (rdy && m_doomed) begin
        m_doomed = 1'b0; m_pc = m_redir;
        if (!st) set_bubble();
      end else if (rdy && !st) begin
        deliver(rd);
      end else if (rdy) begin
        m_held = 1'b1; m_held_ins = rd;
      end else if (!st) begin
        set_bubble();
      end
    end
  endtask

  task automatic compare_all();
    chk("imem_req", {31'd0, imem_req}, {31'd0, !m_held});
    if (!m_held) chk("imem_addr", imem_addr, m_pc);
    chk("valid_ID", {31'd0, valid_ID}, {31'd0, m_v});
    chk("instrCode_ID", instrCode_ID, m_ins);
    chk("PC_ID", PC_ID, m_pcid);
    chk("PC4_ID", PC4_ID, m_pc4);
  endtask

  task automatic cycle(input bit rst, input bit st, input bit fl, input logic [31:0] tg,
                       input bit rdy);
    bit          r;
    logic [31:0] rd;
    r  = rdy && !m_held;
    rd = (m_pc | 32'h3) ^ salt;
    reset = rst; stall = st; flush_IF = fl; PC_target = tg;
    imem_ready = r; imem_rdata = r ? rd : 32'hDEAD_BEEF;
    model_step(rst, st, fl, tg, r, rd);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] t;
    reset = 1'b1; stall = 1'b0; flush_IF = 1'b0; imem_ready = 1'b0;
    PC_target = 32'd0; imem_rdata = 32'd0;
    m_held = 1'b0; m_doomed = 1'b0;
    @(posedge clk);
    #1;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_valid", {31'd0, valid_ID}, 32'd0);
    chk("rst_instr", instrCode_ID, BUB);
    chk("rst_pc", PC_ID, 32'h0);
    chk("rst_pc4", PC4_ID, 32'h0);
    chk("rst_req", {31'd0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);

    cycle(0, 0, 0, 0, 1);
    chk("seq_pc0", PC_ID, 32'h0);
    chk("seq_ins0", instrCode_ID, 32'h3);
    chk("seq_v0", {31'd0, valid_ID}, 32'd1);
    cycle(0, 0, 0, 0, 1);
    chk("seq_pc4", PC_ID, 32'h4);
    chk("seq_addr8", imem_addr, 32'h8);

    cycle(0, 1, 0, 0, 1);
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_pc", PC_ID, 32'h4);
    cycle(0, 1, 0, 0, 0);
    chk("hold2_pc", PC_ID, 32'h4);
    chk("hold2_v", {31'd0, valid_ID}, 32'd1);
    cycle(0, 0, 0, 0, 0);
    chk("rel_pc", PC_ID, 32'h8);
    chk("rel_ins", instrCode_ID, 32'hB);
    chk("rel_addr", imem_addr, 32'hC);

    cycle(0, 0, 0, 0, 1);
    chk("to10_addr", imem_addr, 32'h10);
    cycle(0, 0, 1, 32'h100, 0);
    chk("drain_addr", imem_addr, 32'h10);
    chk("drain_v", {31'd0, valid_ID}, 32'd0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    chk("drain3_v", {31'd0, valid_ID}, 32'd0);
    cycle(0, 0, 0, 0, 1);
    chk("drained_v", {31'd0, valid_ID}, 32'd0);
    chk("drained_addr", imem_addr, 32'h100);

    cycle(0, 0, 0, 0, 1);
    chk("tgt_pc", PC_ID, 32'h100);
    cycle(0, 1, 1, 32'h200, 1);
    chk("fs_v", {31'd0, valid_ID}, 32'd0);
    chk("fs_ins", instrCode_ID, BUB);
    chk("fs_pc", PC_ID, 32'h0);
    chk("fs_addr", imem_addr, 32'h200);

    cycle(0, 0, 1, 32'hFFFF_FFFC, 1);
    chk("wrap_pre", imem_addr, 32'hFFFF_FFFC);
    cycle(0, 0, 0, 0, 1);
    chk("wrap_pc", PC_ID, 32'hFFFF_FFFC);
    chk("wrap_pc4", PC4_ID, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);

    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 1, 32'h300, 0);
    chk("rdr_addr", imem_addr, 32'h4);
    cycle(1, 0, 0, 0, 0);
    chk("rdr_addr0", imem_addr, 32'h0);
    chk("rdr_v", {31'd0, valid_ID}, 32'd0);
    chk("rdr_req", {31'd0, imem_req}, 32'd1);

    salt = $urandom;
    for (int i = 0; i < 4000; i++) begin
      t = $urandom;
      t[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) t = 32'hFFFF_FFF8 | {28'd0, 4'($urandom_range(0, 1) * 4)};
      cycle($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 7) == 0, t, $urandom_range(0, 1) == 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
